// File: rtl/dec_saidas.sv
// rtl/dec_saidas.sv - FIFO-buffered inverse of the ABCD -> S3..S0 substitution encoder
// Codes are queued raw; the decode table is applied combinationally to the head entry.
module dec_saidas #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               code_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               data_out,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         decoded_cnt
);

  localparam int AW = $clog2(DEPTH);

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic          readyEn;
  logic          doPush;
  logic          doPop;
  logic [3:0]    headCode;
  logic [3:0]    decoded;

  // DEPTH is a power of two, so the level MSB alone marks "full".
  assign in_ready  = readyEn && !level[AW];
  assign out_valid = |level;
  assign doPush    = in_valid && in_ready;
  assign doPop     = out_valid && out_ready;
  assign headCode  = mem[rdPtr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      level       <= '0;
      decoded_cnt <= '0;
      readyEn     <= 1'b0;
    end else begin
      readyEn <= 1'b1;
      if (doPush) begin
        wrPtr <= wrPtr + AW'(1);
      end
      if (doPop) begin
        rdPtr       <= rdPtr + AW'(1);
        decoded_cnt <= decoded_cnt + CNT_W'(1);
      end
      case ({doPush, doPop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: emptiness is tracked by level alone.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr] <= code_in;
    end
  end

  always_comb begin
    decoded = 4'd0;
    case (headCode)
      4'd0:  decoded = 4'd9;
      4'd1:  decoded = 4'd12;
      4'd2:  decoded = 4'd5;
      4'd3:  decoded = 4'd13;
      4'd4:  decoded = 4'd14;
      4'd5:  decoded = 4'd4;
      4'd6:  decoded = 4'd2;
      4'd7:  decoded = 4'd8;
      4'd8:  decoded = 4'd10;
      4'd9:  decoded = 4'd1;
      4'd10: decoded = 4'd11;
      4'd11: decoded = 4'd0;
      4'd12: decoded = 4'd6;
      4'd13: decoded = 4'd15;
      4'd14: decoded = 4'd7;
      4'd15: decoded = 4'd3;
      default: decoded = 4'd0;
    endcase
  end

  assign data_out = out_valid ? decoded : 4'd0;

endmodule

// File: tb/tb_dec_saidas.sv
// tb/tb_dec_saidas.sv - self-checking bench for dec_saidas
// A queue-based model predicts every output; directed steps add literal expectations.
module tb_dec_saidas;

  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] code_in = 4'd0;
  logic       out_ready = 1'b0;

  logic       inReady, outValid;
  logic [3:0] dataOut;
  logic [1:0] level;
  logic [7:0] decodedCnt;

  logic       inReady4, outValid4;
  logic [3:0] dataOut4;
  logic [1:0] level4;
  logic [3:0] decodedCnt4;

  dec_saidas #(.DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(inReady),
    .code_in(code_in), .out_valid(outValid), .out_ready(out_ready),
    .data_out(dataOut), .level(level), .decoded_cnt(decodedCnt)
  );

  dec_saidas #(.DEPTH(DEPTH), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(inReady4),
    .code_in(code_in), .out_valid(outValid4), .out_ready(out_ready),
    .data_out(dataOut4), .level(level4), .decoded_cnt(decodedCnt4)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int tbl [16] = '{9, 12, 5, 13, 14, 4, 2, 8, 10, 1, 11, 0, 6, 15, 7, 3};

  // Model state: queue of raw codes, ready flag, pop counter.
  int mq[$];
  bit mReady = 1'b0;
  int mCnt = 0;
  int got[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkSeq(input string name, input int exp[$]);
    check({name, " count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      check(name, got[i], exp[i]);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      mReady = 1'b0;
      mCnt = 0;
    end else begin
      bit doPush, doPop;
      doPush = in_valid && mReady && (mq.size() < DEPTH);
      doPop  = (mq.size() > 0) && out_ready;
      if (doPop) begin
        void'(mq.pop_front());
        mCnt++;
      end
      if (doPush) mq.push_back(int'(code_in));
      mReady = 1'b1;
    end
  end

  // Inputs change just after posedge, so at negedge they describe the coming edge.
  always @(negedge clk) begin
    int expData;
    expData = (mq.size() > 0) ? tbl[mq[0]] : 0;
    check("in_ready", inReady, (mReady && mq.size() < DEPTH) ? 1 : 0);
    check("out_valid", outValid, (mq.size() > 0) ? 1 : 0);
    check("data_out", dataOut, expData);
    check("level", level, mq.size());
    check("decoded_cnt", decodedCnt, mCnt % 256);
    check("cnt4 decoded_cnt", decodedCnt4, mCnt % 16);
    check("cnt4 data_out", dataOut4, expData);
    if (reset && outValid && out_ready) got.push_back(int'(dataOut));
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int c);
    in_valid = 1'b1;
    code_in = 4'(c);
    cyc();
  endtask

  int e[$];
  int t1Codes[16] = '{11, 9, 6, 15, 5, 2, 12, 14, 7, 0, 8, 10, 1, 3, 4, 13};

  initial begin
    // 1: full table through the FIFO
    cyc(2);
    reset = 1'b1;
    cyc();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) push(t1Codes[i]);
    in_valid = 1'b0;
    cyc(3);
    e.delete();
    for (int i = 0; i < 16; i++) e.push_back(i);
    checkSeq("t1 order", e);
    check("t1 decoded_cnt", decodedCnt, 16);

    // 2: fill to full with consumer stalled
    got.delete();
    out_ready = 1'b0;
    push(3); push(4); push(5);
    in_valid = 1'b0;
    check("t2 level", level, 2);
    check("t2 in_ready", inReady, 0);
    check("t2 data_out", dataOut, 13);
    out_ready = 1'b1;
    cyc(3);
    e = '{13, 14};
    checkSeq("t2 order", e);
    check("t2 out_valid", outValid, 0);

    // 3: simultaneous push/pop and pointer wrap
    got.delete();
    out_ready = 1'b0;
    push(6);
    check("t3 level one", level, 1);
    out_ready = 1'b1;
    push(0);
    check("t3 level held", level, 1);
    in_valid = 1'b0;
    cyc(2);
    e = '{2, 9};
    checkSeq("t3 order", e);
    got.delete();
    for (int i = 0; i < 10; i++) push(i);
    in_valid = 1'b0;
    cyc(3);
    e = '{9, 12, 5, 13, 14, 4, 2, 8, 10, 1};
    checkSeq("t3 wrap order", e);

    // 4: asynchronous reset while full
    out_ready = 1'b0;
    push(7); push(13);
    in_valid = 1'b0;
    check("t4 full level", level, 2);
    #3;
    reset = 1'b0;
    #1;
    check("t4 rst level", level, 0);
    check("t4 rst out_valid", outValid, 0);
    check("t4 rst data_out", dataOut, 0);
    check("t4 rst decoded_cnt", decodedCnt, 0);
    check("t4 rst in_ready", inReady, 0);
    cyc();
    check("t4 in_ready held low", inReady, 0);
    reset = 1'b1;
    cyc();
    check("t4 in_ready after release", inReady, 1);
    push(11);
    in_valid = 1'b0;
    check("t4 out_valid", outValid, 1);
    check("t4 data_out", dataOut, 0);
    out_ready = 1'b1;
    cyc(2);

    // 5: 4-bit counter wrap after 17 pops
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    for (int i = 0; i < 17; i++) push(i % 16);
    in_valid = 1'b0;
    cyc(3);
    check("t5 cnt4 wrap", decodedCnt4, 1);
    check("t5 cnt8", decodedCnt, 17);

    // 6: random handshakes, model-checked every cycle
    for (int i = 0; i < 1000; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      code_in = 4'($urandom_range(0, 15));
      cyc();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc(4);
    check("t6 drained level", level, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dec_saidas.md
Name: dec_saidas

Overview:
- Inverse of the 4-bit ABCD -> S3..S0 substitution encoder: accepts encoded codes S3..S0 and recovers the original ABCD word.
- Buffers codes in a small FIFO with valid/ready handshakes on both sides.
- Counts decoded words.
- Sits between the encoder output (or a link carrying its codes) and the per-bit Display instances, which are driven from the data_out bits.

Parameters:
DEPTH, 2, FIFO entries (power of two, >= 2)
CNT_W, 8, width of decoded-word counter

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  input  1  code_in holds a valid code this cycle
in_ready  output  1  block can accept a code this cycle
code_in  input  4  encoded code, bit3 = S3 ... bit0 = S0
out_valid  output  1  data_out holds a decoded word
out_ready  input  1  consumer takes data_out this cycle
data_out  output  4  decoded word, bit3 = A, bit2 = B, bit1 = C, bit0 = D
level  output  clog2(DEPTH)+1  current FIFO occupancy
decoded_cnt  output  CNT_W  number of words popped since reset

Behaviour:
- Reset (reset = 0, async, no clock needed):
  - FIFO empty, pointers = 0, level = 0, decoded_cnt = 0.
  - out_valid = 0, data_out = 0, in_ready = 0 while reset is held.
  - in_ready goes 1 on the first clk edge after reset deasserts.
  - Reset mid-operation discards all buffered entries immediately.
- Decode table, combinational on the FIFO head entry (code -> data):
  - 0->9, 1->12, 2->5, 3->13, 4->14, 5->4, 6->2, 7->8
  - 8->10, 9->1, 10->11, 11->0, 12->6, 13->15, 14->7, 15->3
  - Table is a bijection, so there is no error case.
- Push: in_valid && in_ready at an edge writes code_in at the write pointer.
  - Write pointer increments mod DEPTH.
- Pop: out_valid && out_ready at an edge advances the read pointer mod DEPTH.
  - decoded_cnt increments, wrapping from 2^CNT_W-1 to 0 with no flag.
- in_ready = (level < DEPTH) and not in reset.
  - Registered state only; no combinational path from out_ready to in_ready.
  - When full, a same-cycle pop does not enable a push.
- out_valid = (level > 0). data_out = table(head) when out_valid = 1, else 0.
- Latency: a code pushed at edge N gives out_valid = 1 after edge N when the FIFO was empty, i.e. one cycle. There is no bypass.
- Simultaneous push and pop with 0 < level < DEPTH: level unchanged, both pointers advance, and FIFO order is preserved.
- Full (level = DEPTH): in_ready = 0; in_valid is ignored and code_in is not stored.
- Empty: out_ready is ignored; level and decoded_cnt are unchanged.
- Stability rules:
  - code_in and in_valid may change freely when in_ready = 0.
  - data_out and out_valid are held stable while out_valid && !out_ready.
- Pointer wrap at DEPTH-1 -> 0 must keep order. level is the exact occupancy: it never exceeds DEPTH and never underflows.

Test Plan:
1. Assert reset = 0, then release; hold out_ready = 1; push the 16 encoder outputs in order 11, 9, 6, 15, 5, 2, 12, 14, 7, 0, 8, 10, 1, 3, 4, 13, one per cycle -> data_out = 0, 1, 2 ... 15 in order, each one cycle after its push; decoded_cnt = 16.
2. Hold out_ready = 0; push 3, 4, 5 -> after 2 pushes level = 2 and in_ready = 0; code 5 is not stored; data_out stays 13 (from code 3); then out_ready = 1 -> outputs 13, 14, then out_valid = 0.
3. level = 1 (code 6 queued); push code 0 while popping -> level stays 1; outputs 2 then 9; run 10 cycles of continuous push/pop to cover pointer wrap with no reordering.
4. Push codes 7 and 13 (FIFO full), then drive reset = 0 between clock edges -> level = 0, out_valid = 0, data_out = 0, decoded_cnt = 0 immediately; after release, push code 11 -> data_out = 0.
5. Set CNT_W = 4; pop 17 words -> decoded_cnt wraps to 1.
6. Random in_valid/out_ready over 1000 cycles, checked against a reference model -> every pushed code appears decoded exactly once, in order; no pop when empty; no push when full.
